// File: rtl/servo_uart_pkg.sv
// Shared definitions for the servo UART link: clock/baud defaults, bit-period
// derivation, frame header and the telemetry frame-state encoding.
package servo_uart_pkg;

   localparam int         CLK_FREQ_DEFAULT  = 50_000_000;
   localparam int         BAUD_RATE_DEFAULT = 9600;
   localparam logic [7:0] FRAME_HEADER      = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND_HDR,
      ST_SEND_X,
      ST_SEND_Y,
      ST_SEND_SUM
   } frame_state_t;

   // Whole clocks per serial bit; any fractional remainder is dropped.
   function automatic int baud_tick(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   localparam int BAUD_TICK_DEFAULT = baud_tick(CLK_FREQ_DEFAULT, BAUD_RATE_DEFAULT);

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: accepts one byte on tx_valid while tx_ready, shifts it
// out LSB first, and raises tx_done during the final clock of the stop bit.
module uart_tx_byte #(
   parameter int BAUD_TICK = servo_uart_pkg::BAUD_TICK_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx
);

   localparam int                BAUD_W    = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_TICK - 1);

   logic              active_q, active_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;
   logic [8:0]        shift_q, shift_d;
   logic              tx_q, tx_d;

   // The start bit goes on the line at the accepting edge; the stop bit is the
   // '1' parked above the data in the shift register.
   always_comb begin
      active_d = active_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      if (!active_q) begin
         if (tx_valid) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = 4'd0;
            shift_d  = {1'b1, tx_data};
            tx_d     = 1'b0;
         end
      end else if (baud_q == BAUD_LAST) begin
         baud_d = '0;
         if (bit_q == 4'd9) begin
            active_d = 1'b0;
            tx_d     = 1'b1;
         end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bit_d   = bit_q + 4'd1;
         end
      end else begin
         baud_d = baud_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= 4'd0;
         shift_q  <= '1;
         tx_q     <= 1'b1;
      end else begin
         active_q <= active_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   assign tx_ready = ~active_q;
   assign tx_done  = active_q && (bit_q == 4'd9) && (baud_q == BAUD_LAST);
   assign tx       = tx_q;

endmodule

// File: rtl/servo_telemetry_tx.sv
// Periodic X/Y position reporter: sends HEADER, X, Y, checksum as 8N1 bytes on
// a timer wrap or host request, with requests coalescing into one pending frame.
module servo_telemetry_tx
   import servo_uart_pkg::*;
#(
   parameter int         CLK_FREQ      = CLK_FREQ_DEFAULT,
   parameter int         BAUD_RATE     = BAUD_RATE_DEFAULT,
   parameter int         REPORT_PERIOD = 5_000_000,
   parameter logic [7:0] HEADER        = FRAME_HEADER
) (
   input  logic       clk50mhz,
   input  logic       rst,
   input  logic [7:0] x_position,
   input  logic [7:0] y_position,
   input  logic       report_req,
   output logic       uart_tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int                 BAUD_TICK  = baud_tick(CLK_FREQ, BAUD_RATE);
   localparam int                 TIMER_W    = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REPORT_PERIOD - 1);

   frame_state_t       state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               pending_q, pending_d;
   logic               busy_q, busy_d;
   logic               frame_done_q, frame_done_d;
   logic               tx_valid_q, tx_valid_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic [7:0]         x_snap_q, x_snap_d;
   logic [7:0]         y_snap_q, y_snap_d;
   logic [7:0]         sum_q, sum_d;
   logic               timer_wrap;
   logic               tx_ready;
   logic               tx_done;

   uart_tx_byte #(
      .BAUD_TICK (BAUD_TICK)
   ) u_tx (
      .clk      (clk50mhz),
      .rst      (rst),
      .tx_valid (tx_valid_q),
      .tx_data  (tx_data_q),
      .tx_ready (tx_ready),
      .tx_done  (tx_done),
      .tx       (uart_tx)
   );

   // Each byte is queued on the edge that ends the previous stop bit, so the
   // serializer picks it up one idle clock later.
   always_comb begin
      timer_wrap   = (timer_q == TIMER_LAST);
      timer_d      = timer_wrap ? '0 : timer_q + 1'b1;
      state_d      = state_q;
      pending_d    = pending_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      tx_valid_d   = tx_valid_q & ~tx_ready;
      tx_data_d    = tx_data_q;
      x_snap_d     = x_snap_q;
      y_snap_d     = y_snap_q;
      sum_d        = sum_q;
      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               state_d    = ST_LOAD;
               busy_d     = 1'b1;
               x_snap_d   = x_position;
               y_snap_d   = y_position;
               tx_valid_d = 1'b1;
               tx_data_d  = HEADER;
            end
         end
         ST_LOAD: begin
            sum_d     = HEADER + x_snap_q + y_snap_q;
            pending_d = 1'b0;
            state_d   = ST_SEND_HDR;
         end
         ST_SEND_HDR: begin
            if (tx_done) begin
               state_d    = ST_SEND_X;
               tx_valid_d = 1'b1;
               tx_data_d  = x_snap_q;
            end
         end
         ST_SEND_X: begin
            if (tx_done) begin
               state_d    = ST_SEND_Y;
               tx_valid_d = 1'b1;
               tx_data_d  = y_snap_q;
            end
         end
         ST_SEND_Y: begin
            if (tx_done) begin
               state_d    = ST_SEND_SUM;
               tx_valid_d = 1'b1;
               tx_data_d  = sum_q;
            end
         end
         ST_SEND_SUM: begin
            if (tx_done) begin
               state_d      = ST_IDLE;
               busy_d       = 1'b0;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A new request always wins over the LOAD clear: it arrived after the snapshot.
      if (report_req || timer_wrap) pending_d = 1'b1;
   end

   always_ff @(posedge clk50mhz or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         pending_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= 8'h00;
         x_snap_q     <= 8'h00;
         y_snap_q     <= 8'h00;
         sum_q        <= 8'h00;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         pending_q    <= pending_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         x_snap_q     <= x_snap_d;
         y_snap_q     <= y_snap_d;
         sum_q        <= sum_d;
      end
   end

   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_servo_telemetry_tx.sv
// Bench for servo_telemetry_tx: a frame-schedule model checked every cycle on two
// instances (request-driven and timer-driven), plus directed literal checks.
module tb_servo_telemetry_tx;

   localparam int CLK_HZ   = 50_000_000;
   localparam int BAUD_A   = 960_000;
   localparam int BT_A     = 52;
   localparam int PERIOD_A = 1_000_000;
   localparam int BAUD_B   = 1_000_000;
   localparam int BT_B     = 50;
   localparam int PERIOD_B = 1000;
   localparam int FRAME_A  = 40 * BT_A + 3;

   logic       clk = 1'b0;
   logic       rst_a, rst_b, req_a, req_b;
   logic [7:0] x_a, y_a, x_b, y_b;
   logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   int         m_rel[2], m_load[2], m_bt[2], m_period[2];
   bit         m_pend[2];
   logic [7:0] m_bytes[2][4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   servo_telemetry_tx #(
      .CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD_A), .REPORT_PERIOD(PERIOD_A), .HEADER(8'hA5)
   ) dut_a (
      .clk50mhz(clk), .rst(rst_a), .x_position(x_a), .y_position(y_a),
      .report_req(req_a), .uart_tx(tx_a), .busy(busy_a), .frame_done(done_a)
   );

   servo_telemetry_tx #(
      .CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD_B), .REPORT_PERIOD(PERIOD_B), .HEADER(8'hA5)
   ) dut_b (
      .clk50mhz(clk), .rst(rst_b), .x_position(x_b), .y_position(y_b),
      .report_req(req_b), .uart_tx(tx_b), .busy(busy_b), .frame_done(done_b)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model in terms of frames: a frame is a load edge plus four bytes; the line
   // level at any edge follows from the offset into the 10-bit/byte schedule.
   task automatic model_step(input int d, input logic rstv, input logic req,
                             input logic [7:0] x, input logic [7:0] y);
      int  e, fend;
      bit  wrap, idle;
      if (rstv) begin
         m_rel[d]  = 0;
         m_pend[d] = 1'b0;
         m_load[d] = -1;
      end else begin
         m_rel[d]++;
         e    = m_rel[d];
         wrap = (e % m_period[d]) == 0;
         fend = m_load[d] + 1 + 40 * m_bt[d] + 3;
         idle = (m_load[d] < 0) || (e > fend);
         if (idle && m_pend[d]) begin
            m_load[d]     = e;
            m_bytes[d][0] = 8'hA5;
            m_bytes[d][1] = x;
            m_bytes[d][2] = y;
            m_bytes[d][3] = 8'((9'h0A5 + 9'(x) + 9'(y)) % 256);
         end
         if (req || wrap) m_pend[d] = 1'b1;
         else if (m_load[d] >= 0 && e == m_load[d] + 1) m_pend[d] = 1'b0;
      end
   endtask

   function automatic logic exp_tx(input int d);
      int s, off, k, w, b;
      if (m_load[d] < 0) return 1'b1;
      s = m_load[d] + 1;
      if (m_rel[d] < s || m_rel[d] >= s + 40 * m_bt[d] + 3) return 1'b1;
      off = m_rel[d] - s;
      k   = off / (10 * m_bt[d] + 1);
      w   = off % (10 * m_bt[d] + 1);
      if (w == 10 * m_bt[d]) return 1'b1;
      b = w / m_bt[d];
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_bytes[d][k][b-1];
   endfunction

   function automatic logic exp_busy(input int d);
      return (m_load[d] >= 0) && (m_rel[d] >= m_load[d]) &&
             (m_rel[d] < m_load[d] + 1 + 40 * m_bt[d] + 3);
   endfunction

   function automatic logic exp_done(input int d);
      return (m_load[d] >= 0) && (m_rel[d] == m_load[d] + 1 + 40 * m_bt[d] + 3);
   endfunction

   always @(posedge clk) begin
      model_step(0, rst_a, req_a, x_a, y_a);
      model_step(1, rst_b, req_b, x_b, y_b);
      #1;
      checkOutput("tx_a",   32'(tx_a),   32'(exp_tx(0)));
      checkOutput("busy_a", 32'(busy_a), 32'(exp_busy(0)));
      checkOutput("done_a", 32'(done_a), 32'(exp_done(0)));
      checkOutput("tx_b",   32'(tx_b),   32'(exp_tx(1)));
      checkOutput("busy_b", 32'(busy_b), 32'(exp_busy(1)));
      checkOutput("done_b", 32'(done_b), 32'(exp_done(1)));
   end

   task automatic pulseReq();
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, output int req_edge);
      x_a      = x;
      y_a      = y;
      req_edge = cyc + 1;
      pulseReq();
   endtask

   task automatic decode_byte(output logic [7:0] b, output int start_edge);
      int guard = 0;
      b = 8'h00;
      while (tx_a !== 1'b0 && guard < 4 * BT_A) begin
         @(negedge clk);
         guard++;
      end
      start_edge = cyc;
      checkOutput("start_edge_seen", 32'(tx_a), 32'd0);
      repeat (BT_A / 2) @(negedge clk);
      checkOutput("start_mid", 32'(tx_a), 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (BT_A) @(negedge clk);
         b[i] = tx_a;
      end
      repeat (BT_A) @(negedge clk);
      checkOutput("stop_mid", 32'(tx_a), 32'd1);
   endtask

   task automatic decode_frame(output logic [31:0] f, output int start_edge);
      logic [7:0] b;
      int         s;
      f = '0;
      start_edge = 0;
      for (int k = 0; k < 4; k++) begin
         decode_byte(b, s);
         if (k == 0) start_edge = s;
         f[8*k +: 8] = b;
      end
   endtask

   task automatic wait_done_a(output int done_edge);
      int guard = 0;
      while (done_a !== 1'b1 && guard < 3 * FRAME_A) begin
         @(negedge clk);
         guard++;
      end
      done_edge = cyc;
      checkOutput("done_a_seen", 32'(done_a), 32'd1);
   endtask

   task automatic run_a();
      int         req_edge, s, d1, d2, cnt;
      logic [31:0] f;

      // Basic frame: content and request-to-done latency
      applyStimulus(8'h10, 8'h20, req_edge);
      decode_frame(f, s);
      checkOutput("f1_bytes", f, 32'hD5_20_10_A5);
      wait_done_a(d1);
      checkOutput("f1_latency", 32'(d1 - req_edge), 32'(FRAME_A + 2));
      repeat (20) @(negedge clk);

      // Checksum carry dropped; frame length from header start bit
      applyStimulus(8'hC0, 8'hC0, req_edge);
      decode_frame(f, s);
      checkOutput("f2_bytes", f, 32'h25_C0_C0_A5);
      checkOutput("model_sum_c0", 32'(m_bytes[0][3]), 32'h25);
      wait_done_a(d1);
      checkOutput("f2_length", 32'(d1 - s), 32'(FRAME_A));
      repeat (20) @(negedge clk);

      // Five requests during a frame coalesce into one extra frame
      applyStimulus(8'h11, 8'h22, req_edge);
      for (int k = 0; k < 5; k++) begin
         repeat (150) @(negedge clk);
         pulseReq();
      end
      wait_done_a(d1);
      cnt = 0;
      while (busy_a === 1'b0 && cnt < 10) begin
         cnt++;
         @(negedge clk);
      end
      checkOutput("busy_gap", 32'(cnt), 32'd1);
      wait_done_a(d2);
      checkOutput("f4_spacing", 32'(d2 - d1), 32'(FRAME_A + 2));
      cnt = 0;
      repeat (300) begin
         @(negedge clk);
         if (busy_a !== 1'b0) cnt++;
      end
      checkOutput("no_third_frame", 32'(cnt), 32'd0);

      // Position change during the header is only seen by the next frame
      applyStimulus(8'h10, 8'h20, req_edge);
      repeat (100) @(negedge clk);
      x_a = 8'h80;
      checkOutput("model_snap_x", 32'(m_bytes[0][1]), 32'h10);
      pulseReq();
      wait_done_a(d1);
      decode_frame(f, s);
      checkOutput("f6_bytes", f, 32'h45_20_80_A5);
      wait_done_a(d2);
      repeat (20) @(negedge clk);

      // Reset while the Y byte's bit0 (a zero) is on the line
      applyStimulus(8'h80, 8'h20, req_edge);
      repeat (2 + 20 * BT_A + 2 + BT_A + BT_A / 2 - 2) @(negedge clk);
      checkOutput("pre_reset_tx", 32'(tx_a), 32'd0);
      rst_a = 1'b1;
      #1;
      checkOutput("async_rst_tx", 32'(tx_a), 32'd1);
      checkOutput("async_rst_busy", 32'(busy_a), 32'd0);
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      cnt = 0;
      repeat (3000) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0) cnt++;
      end
      checkOutput("no_residual", 32'(cnt), 32'd0);
      applyStimulus(8'h01, 8'h02, req_edge);
      decode_frame(f, s);
      checkOutput("f8_bytes", f, 32'hA8_02_01_A5);
      wait_done_a(d1);
   endtask

   task automatic run_b(input int rel0);
      int guard;
      guard = 0;
      while (tx_b !== 1'b0 && guard < 1500) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("b_first_start", 32'(cyc - rel0), 32'd1002);
      guard = 0;
      while (done_b !== 1'b1 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("b_first_done", 32'(cyc - rel0), 32'd3005);
      guard = 0;
      while (tx_b !== 1'b0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("b_second_start", 32'(cyc - rel0), 32'd3007);
   endtask

   initial begin
      m_bt[0] = BT_A;  m_period[0] = PERIOD_A;
      m_bt[1] = BT_B;  m_period[1] = PERIOD_B;
      for (int d = 0; d < 2; d++) begin
         m_rel[d]  = 0;
         m_load[d] = -1;
         m_pend[d] = 1'b0;
      end
      rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
      x_a = 8'h00; y_a = 8'h00; x_b = 8'h33; y_b = 8'h44;
      repeat (3) @(negedge clk);
      checkOutput("reset_tx",   32'(tx_a),   32'd1);
      checkOutput("reset_busy", 32'(busy_a), 32'd0);
      checkOutput("reset_done", 32'(done_a), 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      fork
         run_a();
         run_b(cyc);
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/servo_telemetry_tx.md
# servo_telemetry_tx

Periodic UART transmitter that reports the current X/Y servo positions back to the host over a single TX line. It is the return path of the servo link: the host sends target bytes in, and this block sends the smoothed position bytes out as fixed 4-byte frames. It runs at the same 8N1 framing and baud rate as the command path. It sits beside the position-smoothing logic and samples its `x_position`/`y_position` registers.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz
- `BAUD_RATE`, 9600, serial bit rate
- `REPORT_PERIOD`, 5000000, clocks between automatic reports (100 ms)
- `HEADER`, 8'hA5, first byte of every frame
- `clk50mhz`  in  1  system clock; one clock, all logic rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `x_position`  in  8  current X servo position (0–255)
- `y_position`  in  8  current Y servo position (0–255)
- `report_req`  in  1  single-cycle request for an immediate report
- `uart_tx`  out  1  serial output, idle high, 8N1, LSB first
- `busy`  out  1  high while a frame is being loaded or sent
- `frame_done`  out  1  one-cycle pulse when a frame's last stop bit completes

## Operation
- Frame is 4 bytes in order: `HEADER`, X snapshot, Y snapshot, checksum.
- Checksum is `(HEADER + X + Y) mod 256`; carries are discarded.
- Each byte is one start bit (0), data bits 0..7, and one stop bit (1).
- `BAUD_TICK = CLK_FREQ / BAUD_RATE`, using integer division (5208 at the defaults). Every bit is held exactly `BAUD_TICK` clocks.
- Period timer:
  - Free-running; runs whether or not a frame is in flight.
  - Counts 0..`REPORT_PERIOD`-1, then wraps.
  - Raises `pending` when it wraps.
- `report_req` also raises `pending`.
- Timer wrap and `report_req` in the same cycle, or any number of requests while busy, coalesce into a single pending frame.
- Frame FSM states: IDLE → LOAD → SEND_HDR → SEND_X → SEND_Y → SEND_SUM → IDLE.
  - IDLE: if `pending`, go to LOAD.
  - LOAD: snapshot `x_position`/`y_position`, compute checksum, clear `pending`, then go to SEND_HDR.
  - SEND_* states: hand one byte to the serializer and wait for its done flag.
- Positions that change after LOAD do not affect the frame in flight.
- Reset:
  - `uart_tx`=1, `busy`=0, `frame_done`=0, timer=0, `pending`=0, FSM=IDLE, serializer idle.
  - Reset asserted mid-frame drives the line high immediately. The frame is abandoned and never resumed.

## Timing
- `report_req` sampled high at edge N (block idle): `busy`=1 from edge N+1 (LOAD); snapshot taken at edge N+1; header start bit on `uart_tx` from edge N+2.
- Inter-byte gap: exactly 1 clock of idle-high between a stop bit's last cycle and the next start bit.
- Frame length, from header start bit to the end of the checksum stop bit: `40*BAUD_TICK + 3` clocks (208323 at the defaults).
- End of frame: the cycle after the checksum stop bit, `frame_done`=1 for one cycle and `busy`=0.
- `pending` set during a frame:
  - `busy` stays low for exactly one cycle after `frame_done`.
  - It then re-enters LOAD.
  - The next start bit follows one cycle later.
- Timer first wraps `REPORT_PERIOD` clocks after reset release. Its header start bit appears 2 clocks after the wrap edge.

## Structure
- Shared package `servo_uart_pkg`:
  - `CLK_FREQ` and `BAUD_RATE` defaults
  - `BAUD_TICK` derivation
  - `HEADER` constant
  - frame-state enum
- The command receiver uses the same package.
- Sub-module `uart_tx_byte`:
  - Byte serializer with a `tx_valid`/`tx_ready` handshake, 8-bit data, and a one-cycle `tx_done`.
  - Owns its baud counter and bit counter.
- The top level holds the period timer, `pending` flag, frame FSM, snapshot registers and checksum.

## Test plan
- Reset release, `x_position`=8'h10, `y_position`=8'h20, one `report_req` → line decodes A5 10 20 D5; `frame_done` comes 208323+2 clocks after the request edge.
- `x_position`=8'hC0, `y_position`=8'hC0 → checksum 8'h25 (carry dropped). Check every bit's width is exactly 5208 clocks.
- `report_req` pulsed 5 times during a frame → exactly one extra frame; `busy` low for exactly one cycle between the two frames.
- Change `x_position` from 8'h10 to 8'h80 during SEND_HDR → frame still carries 8'h10; the following frame carries 8'h80.
- With `REPORT_PERIOD`=1000 and `BAUD_RATE`=1000000, no `report_req` → the first header start bit appears at clock 1002 after reset; frames then repeat on the timer, with coalescing while busy.
- Assert `rst` in the middle of the Y byte → `uart_tx`=1 asynchronously and `busy`=0. After release, no residual bits appear until the next request.
